// File: rtl/snake_collision_scanner.sv
// Collision scanner: after each snake move, walks the body list one segment per
// cycle and reports wall, self and apple hits for the new head position.
module snake_collision_scanner #(
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120,
   parameter int DIM     = 10,
   parameter int MAXLEN  = 16,
   parameter int IW      = 4
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          start,
   input  logic [IW:0]   length,
   input  logic [7:0]    head_x,
   input  logic [6:0]    head_y,
   input  logic [7:0]    apple_x,
   input  logic [6:0]    apple_y,
   output logic [IW-1:0] seg_idx,
   input  logic [7:0]    seg_x,
   input  logic [6:0]    seg_y,
   output logic          busy,
   output logic          done,
   output logic          hit_wall,
   output logic          hit_self,
   output logic          hit_apple
);

   localparam int LW = IW + 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_SCAN  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [7:0]    X_LIM = 8'(XSCREEN - DIM);
   localparam logic [6:0]    Y_LIM = 7'(YSCREEN - DIM);
   localparam logic [LW-1:0] MAX_L = LW'(MAXLEN);

   // Squares overlap when both axis distances are strictly below DIM; no wrap.
   function automatic logic overlap(input logic [7:0] ax, input logic [6:0] ay,
                                    input logic [7:0] bx, input logic [6:0] by);
      logic signed [8:0] dx;
      logic signed [7:0] dy;
      logic [8:0] adx;
      logic [7:0] ady;
      dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
      adx = dx[8] ? $unsigned(-dx) : $unsigned(dx);
      ady = dy[7] ? $unsigned(-dy) : $unsigned(dy);
      return (adx < 9'(DIM)) && (ady < 8'(DIM));
   endfunction

   logic [1:0]    state_r, state_s;
   logic [7:0]    head_x_r, head_x_s, apple_x_r, apple_x_s;
   logic [6:0]    head_y_r, head_y_s, apple_y_r, apple_y_s;
   logic [LW-1:0] len_r, len_s, eff_len_s;
   logic [IW-1:0] seg_idx_r, seg_idx_s;
   logic          busy_r, busy_s, done_r, done_s;
   logic          hit_wall_r, hit_wall_s, hit_self_r, hit_self_s, hit_apple_r, hit_apple_s;
   logic          wall_s, apple_ov_s, seg_ov_s, last_s;

   // Clamp the requested length to 1..MAXLEN and evaluate the hit predicates.
   always_comb begin
      if (length == {LW{1'b0}}) begin
         eff_len_s = LW'(1);
      end else if (length > MAX_L) begin
         eff_len_s = MAX_L;
      end else begin
         eff_len_s = length;
      end
      wall_s     = (head_x_r > X_LIM) || (head_y_r > Y_LIM);
      apple_ov_s = overlap(head_x_r, head_y_r, apple_x_r, apple_y_r);
      seg_ov_s   = overlap(head_x_r, head_y_r, seg_x, seg_y);
      last_s     = ({1'b0, seg_idx_r} == (len_r - LW'(1)));
   end

   // Next-state and next-output logic for the scan sequencer.
   always_comb begin
      state_s     = state_r;
      head_x_s    = head_x_r;
      head_y_s    = head_y_r;
      apple_x_s   = apple_x_r;
      apple_y_s   = apple_y_r;
      len_s       = len_r;
      seg_idx_s   = {IW{1'b0}};
      hit_wall_s  = hit_wall_r;
      hit_self_s  = hit_self_r;
      hit_apple_s = hit_apple_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               head_x_s    = head_x;
               head_y_s    = head_y;
               apple_x_s   = apple_x;
               apple_y_s   = apple_y;
               len_s       = eff_len_s;
               hit_wall_s  = 1'b0;
               hit_self_s  = 1'b0;
               hit_apple_s = 1'b0;
               state_s     = S_CHECK;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_CHECK: begin
            hit_wall_s  = wall_s;
            hit_apple_s = apple_ov_s;
            if (wall_s || (len_r == LW'(1))) begin
               state_s = S_DONE;
            end else begin
               state_s   = S_SCAN;
               seg_idx_s = IW'(1);
            end
         end
         S_SCAN: begin
            if (seg_ov_s) begin
               hit_self_s = 1'b1;
               state_s    = S_DONE;
            end else if (last_s) begin
               state_s = S_DONE;
            end else begin
               seg_idx_s = seg_idx_r + IW'(1);
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      busy_s = (state_s != S_IDLE);
      done_s = (state_s == S_DONE);
   end

   // State and registered outputs; synchronous reset discards any scan in flight.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_r     <= S_IDLE;
         head_x_r    <= 8'd0;
         head_y_r    <= 7'd0;
         apple_x_r   <= 8'd0;
         apple_y_r   <= 7'd0;
         len_r       <= LW'(1);
         seg_idx_r   <= {IW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         hit_wall_r  <= 1'b0;
         hit_self_r  <= 1'b0;
         hit_apple_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         head_x_r    <= head_x_s;
         head_y_r    <= head_y_s;
         apple_x_r   <= apple_x_s;
         apple_y_r   <= apple_y_s;
         len_r       <= len_s;
         seg_idx_r   <= seg_idx_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         hit_wall_r  <= hit_wall_s;
         hit_self_r  <= hit_self_s;
         hit_apple_r <= hit_apple_s;
      end
   end

   assign seg_idx   = seg_idx_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign hit_wall  = hit_wall_r;
   assign hit_self  = hit_self_r;
   assign hit_apple = hit_apple_r;

endmodule

// File: tb/tb_snake_collision_scanner.sv
// Directed bench for snake_collision_scanner; cycle 1 is the cycle after the start edge.
module tb_snake_collision_scanner;

   logic       Clock, Resetn, start;
   logic [4:0] length;
   logic [7:0] head_x, apple_x, seg_x;
   logic [6:0] head_y, apple_y, seg_y;
   logic [3:0] seg_idx;
   logic       busy, done, hit_wall, hit_self, hit_apple;

   logic [7:0] bx [16];
   logic [6:0] by [16];

   int errors = 0;
   int checks = 0;
   int done_cyc, max_idx, busy_all;
   logic [2:0] flags;          // {wall, self, apple} sampled in the done cycle
   logic [3:0] idx_tr [41];

   snake_collision_scanner dut (
      .Clock(Clock), .Resetn(Resetn), .start(start), .length(length),
      .head_x(head_x), .head_y(head_y), .apple_x(apple_x), .apple_y(apple_y),
      .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y), .busy(busy), .done(done),
      .hit_wall(hit_wall), .hit_self(hit_self), .hit_apple(hit_apple)
   );

   assign seg_x = bx[seg_idx];
   assign seg_y = by[seg_idx];

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic clear_body();
      for (int i = 0; i < 16; i++) begin
         bx[i] = 8'd0;
         by[i] = 7'd0;
      end
   endtask

   task automatic run(input logic [4:0] len, input logic [7:0] hx, input logic [6:0] hy,
                      input logic [7:0] ax, input logic [6:0] ay, input int stray);
      @(negedge Clock);
      length = len; head_x = hx; head_y = hy; apple_x = ax; apple_y = ay; start = 1'b1;
      @(posedge Clock);
      #1 start = 1'b0;
      done_cyc = 0; max_idx = 0; busy_all = 1; flags = 3'b000;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         @(negedge Clock);
         start = (c == stray);
         idx_tr[c] = seg_idx;
         if (int'(seg_idx) > max_idx) max_idx = int'(seg_idx);
         if (busy !== 1'b1) busy_all = 0;
         if (done === 1'b1) begin
            done_cyc = c;
            flags = {hit_wall, hit_self, hit_apple};
         end
      end
      start = 1'b0;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      Resetn = 1'b0; start = 1'b0; length = 5'd0;
      head_x = 8'd0; head_y = 7'd0; apple_x = 8'd0; apple_y = 7'd0;
      clear_body();
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      chk("reset_outputs", int'({busy, done, hit_wall, hit_self, hit_apple, seg_idx}), 0);
      Resetn = 1'b1;
   endtask

   task automatic test_no_hit();
      clear_body();
      bx[1] = 8'd80; by[1] = 7'd60;
      bx[2] = 8'd80; by[2] = 7'd70;
      bx[3] = 8'd80; by[3] = 7'd80;
      run(5'd4, 8'd80, 7'd50, 8'd30, 7'd30, 0);
      chk("nohit_done_cycle", done_cyc, 5);
      chk("nohit_flags", int'(flags), 0);
      chk("nohit_idx_c2", int'(idx_tr[2]), 1);
      chk("nohit_idx_c3", int'(idx_tr[3]), 2);
      chk("nohit_idx_c4", int'(idx_tr[4]), 3);
      chk("nohit_busy_1_5", busy_all, 1);
   endtask

   task automatic test_self_hit();
      run(5'd4, 8'd80, 7'd75, 8'd30, 7'd30, 0);
      chk("self_done_cycle", done_cyc, 4);
      chk("self_flags", int'(flags), 2);
      chk("self_max_idx", max_idx, 2);
   endtask

   task automatic test_wall();
      clear_body();
      run(5'd4, 8'd151, 7'd60, 8'd30, 7'd30, 0);
      chk("wall_done_cycle", done_cyc, 2);
      chk("wall_flag", int'(flags), 4);
      chk("wall_no_scan", max_idx, 0);
      run(5'd4, 8'd255, 7'd60, 8'd30, 7'd30, 0);
      chk("underflow_flag", int'(flags), 4);
      run(5'd2, 8'd150, 7'd110, 8'd30, 7'd30, 0);
      chk("edge_inside_flags", int'(flags), 0);
      chk("edge_inside_done", done_cyc, 3);
   endtask

   task automatic test_apple();
      clear_body();
      bx[1] = 8'd30; by[1] = 7'd45;
      bx[2] = 8'd30; by[2] = 7'd55;
      bx[3] = 8'd30; by[3] = 7'd65;
      run(5'd4, 8'd30, 7'd35, 8'd30, 7'd30, 0);
      chk("apple_flags", int'(flags), 1);
      chk("apple_full_scan", done_cyc, 5);
      bx[1] = 8'd40; by[1] = 7'd40;
      bx[2] = 8'd40; by[2] = 7'd50;
      bx[3] = 8'd40; by[3] = 7'd60;
      run(5'd4, 8'd40, 7'd30, 8'd30, 7'd30, 0);
      chk("apple_touch_flags", int'(flags), 0);
   endtask

   task automatic test_clamp_stray();
      clear_body();
      run(5'd0, 8'd80, 7'd50, 8'd30, 7'd30, 0);
      chk("len0_done_cycle", done_cyc, 2);
      run(5'd31, 8'd80, 7'd50, 8'd30, 7'd30, 0);
      chk("len31_max_idx", max_idx, 15);
      chk("len31_done_cycle", done_cyc, 17);
      run(5'd4, 8'd80, 7'd50, 8'd30, 7'd30, 3);
      chk("stray_done_cycle", done_cyc, 5);
      start = 1'b1;               // asserted during the DONE cycle
      @(negedge Clock);
      start = 1'b0;
      chk("start_in_done_ignored", int'(busy), 0);
   endtask

   task automatic test_back_to_back();
      clear_body();
      run(5'd3, 8'd80, 7'd50, 8'd80, 7'd55, 0);
      chk("b2b_first_done", done_cyc, 4);
      run(5'd3, 8'd151, 7'd50, 8'd30, 7'd30, 0);
      chk("b2b_second_done", done_cyc, 2);
      chk("b2b_second_flags", int'(flags), 4);
   endtask

   task automatic test_reset_mid_scan();
      logic apple_mid;
      clear_body();
      @(negedge Clock);
      length = 5'd8; head_x = 8'd80; head_y = 7'd50; apple_x = 8'd85; apple_y = 7'd55;
      start = 1'b1;
      @(posedge Clock);
      #1 start = 1'b0;
      apple_mid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge Clock);
         if (c == 2) apple_mid = hit_apple;
         if (c == 3) Resetn = 1'b0;
      end
      chk("mid_apple_before_reset", int'(apple_mid), 1);
      @(negedge Clock);
      chk("mid_reset_cleared", int'({busy, done, hit_wall, hit_self, hit_apple}), 0);
      Resetn = 1'b1;
      run(5'd8, 8'd80, 7'd50, 8'd85, 7'd55, 0);
      chk("after_reset_done", done_cyc, 9);
      chk("after_reset_flags", int'(flags), 1);
   endtask

   initial begin
      test_reset();
      test_no_hit();
      test_self_hit();
      test_wall();
      test_apple();
      test_clamp_stray();
      test_back_to_back();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
